// File: rtl/hs_pipe.sv
// Clocked four-phase req/ack FIFO pipeline: DEPTH-entry circular buffer plus an
// output register, with occupancy status and a synchronous flush.
module hs_pipe #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 3,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             ack_in,
  output logic             req_out,
  output logic [WIDTH-1:0] data_out,
  input  logic             ack_out,
  input  logic             flush,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    IN_IDLE = 1'b0,
    IN_ACK  = 1'b1
  } in_state_e;

  typedef enum logic [1:0] {
    OUT_IDLE = 2'b00,
    OUT_REQ  = 2'b01,
    OUT_WAIT = 2'b10
  } out_state_e;

  in_state_e        in_state_q, in_state_d;
  out_state_e       out_state_q, out_state_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_req;
  logic             wr_en;
  logic             pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    ptr_inc = (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_state_q  <= IN_IDLE;
      out_state_q <= OUT_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      data_out_q  <= '0;
    end else begin
      in_state_q  <= in_state_d;
      out_state_q <= out_state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      data_out_q  <= data_out_d;
    end
  end

  // Buffer storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  // Input FSM next state; full is the registered flag, so a slot freed this cycle is not reused until next
  always_comb begin
    in_state_d = in_state_q;
    wr_req     = 1'b0;
    case (in_state_q)
      IN_IDLE: begin
        if (req_in && !full_q) begin
          wr_req     = 1'b1;
          in_state_d = IN_ACK;
        end
      end
      IN_ACK: begin
        if (!req_in) begin
          in_state_d = IN_IDLE;
        end
      end
      default: in_state_d = IN_IDLE;
    endcase
  end

  // Output FSM next state; no pop on a flush cycle
  always_comb begin
    out_state_d = out_state_q;
    pop         = 1'b0;
    case (out_state_q)
      OUT_IDLE: begin
        if (!empty_q && !flush) begin
          pop         = 1'b1;
          out_state_d = OUT_REQ;
        end
      end
      OUT_REQ: begin
        if (ack_out) begin
          out_state_d = OUT_WAIT;
        end
      end
      OUT_WAIT: begin
        if (!ack_out) begin
          out_state_d = OUT_IDLE;
        end
      end
      default: out_state_d = OUT_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state registers
  always_comb begin
    ack_in  = 1'b0;
    req_out = 1'b0;
    if (in_state_q == IN_ACK) begin
      ack_in = 1'b1;
    end
    if (out_state_q == OUT_REQ) begin
      req_out = 1'b1;
    end
  end

  // Pointers, occupancy and output register; a flushed write still completes its handshake
  always_comb begin
    wr_en      = wr_req && !flush;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    if (pop) begin
      data_out_d = mem_q[rd_ptr_q];
    end
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({wr_en, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  assign data_out = data_out_q;
  assign count    = count_q;
  assign full     = full_q;
  assign empty    = empty_q;

endmodule
